downsample_addr_gen: RTL and testbench
======================================

DOWNSAMPLE_ADDR_GEN -- requirements
Module: downsample_addr_gen

Interface
REQ-001 Parameter IMG_W, default 256, source image width in pixels; SHALL be even and >= 2.
REQ-002 Parameter IMG_H, default 256, source image height in pixels; SHALL be even and >= 2.
REQ-003 Parameter AW, default 18, address width, matching the processor data bus.
REQ-004 clk  input  1  single clock; all state updates on the falling edge, as in the rest of the processor datapath.
REQ-005 rst  input  1  reset; synchronous and active-low.
REQ-006 start  input  1  one-cycle request to begin one full down-sample pass.
REQ-007 base_src  input  AW  source image base address; sampled at start.
REQ-008 base_dst  input  AW  destination image base address; sampled at start.
REQ-009 addr_ready  input  1  consumer (bus/swap register load path) accepts addr_out this edge.
REQ-010 addr_out  output  AW  address presented to the processor bus.
REQ-011 addr_valid  output  1  addr_out is valid.
REQ-012 addr_kind  output  3  0=TL, 1=TR, 2=BL, 3=BR source quadrant, 4=destination.
REQ-013 busy  output  1  pass in progress.
REQ-014 done  output  1  one-cycle pulse at pass completion.

Function
REQ-015 FSM states: IDLE, SRC, DST, DONE.
REQ-016 IDLE: start=1 at an edge SHALL latch base_src/base_dst, clear row/col and quad counters, and enter SRC; addr_valid=1 with the TL address from the next edge (1-cycle latency).
REQ-017 Output pixel (r,c): r in 0..IMG_H/2-1, c in 0..IMG_W/2-1, raster order, c fastest.
REQ-018 SRC address = base_src + 2r*IMG_W + 2c + {0, 1, IMG_W, IMG_W+1} for quad 0..3; all sums modulo 2^AW (wrap, no flag).
REQ-019 DST address = base_dst + r*(IMG_W/2) + c, modulo 2^AW.
REQ-020 Transfer = addr_valid & addr_ready at an edge; while addr_valid & !addr_ready, addr_out and addr_kind SHALL be held stable.
REQ-021 SRC: each transfer advances quad; transfer on quad 3 enters DST.
REQ-022 DST: transfer on the last pixel (r=IMG_H/2-1, c=IMG_W/2-1) enters DONE; otherwise it advances c (wrapping to 0 and incrementing r) and returns to SRC, quad 0.
REQ-023 DONE: done=1, addr_valid=0 for exactly one cycle, then IDLE.
REQ-024 busy=1 in SRC, DST and DONE; start while busy SHALL be ignored.
REQ-025 Back-to-back transfers SHALL sustain one address per cycle while addr_ready=1.

Reset
REQ-026 rst=0 at an edge SHALL force IDLE and addr_out=0, addr_valid=0, addr_kind=0, busy=0, done=0, and clear all counters, including when applied mid-pass; rst SHALL take priority over start.

Structure
REQ-027 Shared package holds the FSM state encoding, addr_kind codes (KIND_TL..KIND_DST) and the default AW.
REQ-028 One sub-module, ds_pixel_counter (row/col raster counter with wrap and last-pixel flag), SHALL be used; address arithmetic stays in the top module.

Verification
REQ-029 IMG_W=IMG_H=4, base_src=0, base_dst=100, addr_ready=1 -> 0,1,4,5,100; 2,3,6,7,101; 8,9,12,13,102; 10,11,14,15,103; then done pulse; 20 transfers in 20 cycles.
REQ-030 Same config, addr_ready low for 3 cycles during TR of pixel 0 -> addr_out held at 1 with addr_kind=1 throughout, then the sequence resumes unchanged.
REQ-031 base_src=18'h3FFFF, IMG_W=4 -> first pixel addresses 3FFFF, 00000, 00003, 00004.
REQ-032 rst=0 asserted after the 7th transfer -> next edge: addr_valid=0, busy=0; a new start restarts the pass at TL address base_src.
REQ-033 start pulsed while busy -> ignored; pass completes with exactly 20 transfers and one done pulse.
REQ-034 start and rst=0 in the same cycle -> remains IDLE, addr_valid=0.

Source files
------------

// File: rtl/downsample_addr_gen_pkg.sv
// Shared definitions for the 2x2 down-sample address generator:
// FSM encoding, addr_kind codes, default bus width and a counter-width helper.
package downsample_addr_gen_pkg;

    localparam int DEF_AW = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SRC  = 2'd1,
        ST_DST  = 2'd2,
        ST_DONE = 2'd3
    } ds_state_e;

    typedef enum logic [2:0] {
        KIND_TL  = 3'd0,
        KIND_TR  = 3'd1,
        KIND_BL  = 3'd2,
        KIND_BR  = 3'd3,
        KIND_DST = 3'd4
    } ds_kind_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ds_pixel_counter.sv
// Raster counter over the down-sampled output grid (column fastest).
// Exposes the value the counter will hold after the coming edge so the
// parent can register addresses computed from it, plus a last-pixel flag.
module ds_pixel_counter
    import downsample_addr_gen_pkg::*;
#(
    parameter int COLS = 2,
    parameter int ROWS = 2,
    localparam int CW = cnt_width(COLS),
    localparam int RW = cnt_width(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [RW-1:0] row_nxt,
    output logic [CW-1:0] col_nxt,
    output logic          last
);

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    logic [RW-1:0] row_r;
    logic [CW-1:0] col_r;

    assign last = (row_r == ROW_LAST) && (col_r == COL_LAST);

    // Next raster position: clear wins, advance wraps column then row.
    always_comb begin
        row_nxt = row_r;
        col_nxt = col_r;
        if (clr) begin
            row_nxt = '0;
            col_nxt = '0;
        end else if (adv) begin
            if (col_r == COL_LAST) begin
                col_nxt = '0;
                if (row_r == ROW_LAST) begin
                    row_nxt = '0;
                end else begin
                    row_nxt = row_r + RW'(1);
                end
            end else begin
                col_nxt = col_r + CW'(1);
            end
        end else begin
            row_nxt = row_r;
            col_nxt = col_r;
        end
    end

    // Position register, falling-edge clocked with synchronous active-low reset.
    always_ff @(negedge clk) begin
        if (!rst) begin
            row_r <= '0;
            col_r <= '0;
        end else begin
            row_r <= row_nxt;
            col_r <= col_nxt;
        end
    end

endmodule

// File: rtl/downsample_addr_gen.sv
// 2x2 down-sample address generator: for each output pixel emits the four
// source quadrant addresses followed by the destination address, one per
// accepted transfer. All outputs are registered and computed from the
// next-cycle state so a stalled address stays bit-for-bit stable.
module downsample_addr_gen
    import downsample_addr_gen_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_src,
    input  logic [AW-1:0] base_dst,
    input  logic          addr_ready,
    output logic [AW-1:0] addr_out,
    output logic          addr_valid,
    output logic [2:0]    addr_kind,
    output logic          busy,
    output logic          done
);

    localparam int COLS = IMG_W / 2;
    localparam int ROWS = IMG_H / 2;
    localparam int CW   = cnt_width(COLS);
    localparam int RW   = cnt_width(ROWS);

    localparam logic [AW-1:0] W_A      = AW'(IMG_W);
    localparam logic [AW-1:0] HALF_W_A = AW'(COLS);

    ds_state_e     state_r, state_nxt_s;
    logic [1:0]    quad_r, quad_nxt_s;
    logic [AW-1:0] base_src_r, base_src_nxt_s;
    logic [AW-1:0] base_dst_r, base_dst_nxt_s;
    logic          cnt_clr_s, cnt_adv_s, last_s, xfer_s;
    logic [RW-1:0] row_nxt_s;
    logic [CW-1:0] col_nxt_s;
    logic [AW-1:0] quad_off_s, src_addr_s, dst_addr_s;
    logic [AW-1:0] addr_nxt_s;
    logic [2:0]    kind_nxt_s;
    logic          valid_nxt_s, busy_nxt_s, done_nxt_s;

    assign xfer_s = addr_valid & addr_ready;

    ds_pixel_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr_s),
        .adv     (cnt_adv_s),
        .row_nxt (row_nxt_s),
        .col_nxt (col_nxt_s),
        .last    (last_s)
    );

    // FSM next state, quadrant sequencing, base capture and counter control.
    always_comb begin
        state_nxt_s    = state_r;
        quad_nxt_s     = quad_r;
        base_src_nxt_s = base_src_r;
        base_dst_nxt_s = base_dst_r;
        cnt_clr_s      = 1'b0;
        cnt_adv_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s    = ST_SRC;
                    quad_nxt_s     = 2'd0;
                    base_src_nxt_s = base_src;
                    base_dst_nxt_s = base_dst;
                    cnt_clr_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SRC: begin
                if (xfer_s) begin
                    if (quad_r == 2'd3) begin
                        state_nxt_s = ST_DST;
                    end else begin
                        quad_nxt_s = quad_r + 2'd1;
                    end
                end else begin
                    state_nxt_s = ST_SRC;
                end
            end
            ST_DST: begin
                if (xfer_s) begin
                    if (last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SRC;
                        quad_nxt_s  = 2'd0;
                        cnt_adv_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_DST;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                quad_nxt_s  = 2'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                quad_nxt_s  = 2'd0;
            end
        endcase
    end

    // Address arithmetic for the upcoming cycle; sums wrap modulo 2^AW.
    always_comb begin
        quad_off_s = '0;
        case (quad_nxt_s)
            2'd0:    quad_off_s = '0;
            2'd1:    quad_off_s = AW'(1);
            2'd2:    quad_off_s = W_A;
            2'd3:    quad_off_s = W_A + AW'(1);
            default: quad_off_s = '0;
        endcase
        src_addr_s = base_src_nxt_s
                   + ((AW'(row_nxt_s) << 1) * W_A)
                   + (AW'(col_nxt_s) << 1)
                   + quad_off_s;
        dst_addr_s = base_dst_nxt_s
                   + (AW'(row_nxt_s) * HALF_W_A)
                   + AW'(col_nxt_s);
    end

    // Output values derived from the next state, to be registered.
    always_comb begin
        addr_nxt_s  = '0;
        kind_nxt_s  = KIND_TL;
        valid_nxt_s = 1'b0;
        done_nxt_s  = 1'b0;
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        case (state_nxt_s)
            ST_SRC: begin
                addr_nxt_s  = src_addr_s;
                kind_nxt_s  = {1'b0, quad_nxt_s};
                valid_nxt_s = 1'b1;
            end
            ST_DST: begin
                addr_nxt_s  = dst_addr_s;
                kind_nxt_s  = KIND_DST;
                valid_nxt_s = 1'b1;
            end
            ST_DONE: begin
                done_nxt_s = 1'b1;
            end
            default: begin
                addr_nxt_s  = '0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, captured bases and registered outputs; reset overrides start.
    always_ff @(negedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            quad_r     <= 2'd0;
            base_src_r <= '0;
            base_dst_r <= '0;
            addr_out   <= '0;
            addr_kind  <= 3'd0;
            addr_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            quad_r     <= quad_nxt_s;
            base_src_r <= base_src_nxt_s;
            base_dst_r <= base_dst_nxt_s;
            addr_out   <= addr_nxt_s;
            addr_kind  <= kind_nxt_s;
            addr_valid <= valid_nxt_s;
            busy       <= busy_nxt_s;
            done       <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_downsample_addr_gen.sv
// Scoreboard bench for downsample_addr_gen on a 4x4 image. The DUT updates on
// the falling edge; the bench drives and samples on the rising edge.
module tb_downsample_addr_gen;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int AW    = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_src;
    logic [AW-1:0] base_dst;
    logic          addr_ready;
    logic [AW-1:0] addr_out;
    logic          addr_valid;
    logic [2:0]    addr_kind;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic [AW+2:0] sb_q[$];

    always #5 clk = ~clk;

    downsample_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_src   (base_src),
        .base_dst   (base_dst),
        .addr_ready (addr_ready),
        .addr_out   (addr_out),
        .addr_valid (addr_valid),
        .addr_kind  (addr_kind),
        .busy       (busy),
        .done       (done)
    );

    // Expected {kind, addr} stream of one full pass, from the address formulas.
    task automatic push_pass(input logic [AW-1:0] bs, input logic [AW-1:0] bd);
        for (int r = 0; r < IMG_H / 2; r++) begin
            for (int c = 0; c < IMG_W / 2; c++) begin
                for (int q = 0; q < 4; q++) begin
                    sb_q.push_back({3'(q), bs + AW'(2 * r * IMG_W + 2 * c + (q % 2) + (q / 2) * IMG_W)});
                end
                sb_q.push_back({3'd4, bd + AW'(r * (IMG_W / 2) + c)});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; addr_ready = 1'b0;
        base_src = '0; base_dst = '0;
        repeat (3) @(posedge clk);
        checks++;
        if ({addr_valid, busy, done} !== 3'b000 || addr_out !== '0 || addr_kind !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b addr=%h kind=%0d, required all zero",
                     addr_valid, busy, done, addr_out, addr_kind);
        end
        rst = 1'b1;
        @(posedge clk);
        checks++;
        if (addr_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", addr_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW+2:0] e;
        int nx = 0, nd = 0, first_c = -1, last_c = -1;
        bit fin = 1'b0;
        sb_q.delete();
        push_pass(18'd0, 18'd100);
        base_src = 18'd0; base_dst = 18'd100; addr_ready = 1'b1;
        @(posedge clk); start = 1'b1;
        for (int cyc = 1; cyc <= 100 && !fin; cyc++) begin
            @(posedge clk); start = 1'b0;
            if (addr_valid) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                nx++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: addr=%h kind=%0d, required no transfer", addr_out, addr_kind);
                end else begin
                    e = sb_q.pop_front();
                    if ({addr_kind, addr_out} !== e) begin
                        errors++;
                        $display("FAIL b2b_xfer%0d: kind=%0d addr=%h, required kind=%0d addr=%h",
                                 nx, addr_kind, addr_out, e[AW+2:AW], e[AW-1:0]);
                    end
                end
            end
            if (done) begin
                nd++;
                checks++;
                if (addr_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_done_cycle: valid=%b busy=%b, required 0 1", addr_valid, busy);
                end
            end
            if (!busy && nd > 0) fin = 1'b1;
        end
        checks++;
        if (!fin || nx != 20 || nd != 1) begin
            errors++;
            $display("FAIL b2b_count: finished=%0d transfers=%0d dones=%0d, required 1 20 1", fin, nx, nd);
        end
        checks++;
        if (first_c != 1 || last_c != 20) begin
            errors++;
            $display("FAIL b2b_rate: first=%0d last=%0d, required 1 20", first_c, last_c);
        end
    endtask

    task automatic test_stall();
        logic [AW+2:0] e;
        int nx = 0, nd = 0, stall_left = 0, last_c = -1;
        bit fin = 1'b0, stalled = 1'b0;
        sb_q.delete();
        push_pass(18'd0, 18'd100);
        base_src = 18'd0; base_dst = 18'd100; addr_ready = 1'b1;
        @(posedge clk); start = 1'b1;
        for (int cyc = 1; cyc <= 100 && !fin; cyc++) begin
            @(posedge clk); start = 1'b0;
            if (!stalled && addr_valid && addr_kind == 3'd1) begin
                stalled = 1'b1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                addr_ready = 1'b0;
                stall_left--;
                checks++;
                if (addr_valid !== 1'b1 || addr_out !== 18'd1 || addr_kind !== 3'd1) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b addr=%h kind=%0d, required 1 00001 1",
                             addr_valid, addr_out, addr_kind);
                end
            end else begin
                addr_ready = 1'b1;
                if (addr_valid) begin
                    nx++;
                    last_c = cyc;
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL stall_extra: addr=%h, required no transfer", addr_out);
                    end else begin
                        e = sb_q.pop_front();
                        if ({addr_kind, addr_out} !== e) begin
                            errors++;
                            $display("FAIL stall_xfer%0d: kind=%0d addr=%h, required kind=%0d addr=%h",
                                     nx, addr_kind, addr_out, e[AW+2:AW], e[AW-1:0]);
                        end
                    end
                end
            end
            if (done) nd++;
            if (!busy && nd > 0) fin = 1'b1;
        end
        addr_ready = 1'b1;
        checks++;
        if (!fin || !stalled || nx != 20 || nd != 1 || last_c != 23) begin
            errors++;
            $display("FAIL stall_count: finished=%0d stalled=%0d transfers=%0d dones=%0d last=%0d, required 1 1 20 1 23",
                     fin, stalled, nx, nd, last_c);
        end
    endtask

    task automatic test_wrap();
        logic [AW+2:0] e;
        logic [AW-1:0] wrap_exp [4];
        int nx = 0, nd = 0;
        bit fin = 1'b0;
        wrap_exp[0] = 18'h3FFFF; wrap_exp[1] = 18'h00000;
        wrap_exp[2] = 18'h00003; wrap_exp[3] = 18'h00004;
        sb_q.delete();
        push_pass(18'h3FFFF, 18'h3FFFE);
        base_src = 18'h3FFFF; base_dst = 18'h3FFFE; addr_ready = 1'b1;
        @(posedge clk); start = 1'b1;
        for (int cyc = 1; cyc <= 100 && !fin; cyc++) begin
            @(posedge clk); start = 1'b0;
            if (addr_valid) begin
                if (nx < 4) begin
                    checks++;
                    if (addr_out !== wrap_exp[nx]) begin
                        errors++;
                        $display("FAIL wrap_first%0d: addr=%h, required %h", nx, addr_out, wrap_exp[nx]);
                    end
                end
                nx++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_extra: addr=%h, required no transfer", addr_out);
                end else begin
                    e = sb_q.pop_front();
                    if ({addr_kind, addr_out} !== e) begin
                        errors++;
                        $display("FAIL wrap_xfer%0d: kind=%0d addr=%h, required kind=%0d addr=%h",
                                 nx, addr_kind, addr_out, e[AW+2:AW], e[AW-1:0]);
                    end
                end
            end
            if (done) nd++;
            if (!busy && nd > 0) fin = 1'b1;
        end
        checks++;
        if (!fin || nx != 20 || nd != 1) begin
            errors++;
            $display("FAIL wrap_count: finished=%0d transfers=%0d dones=%0d, required 1 20 1", fin, nx, nd);
        end
    endtask

    task automatic test_mid_reset();
        logic [AW+2:0] e;
        int nx = 0, nd = 0;
        bit fin = 1'b0;
        sb_q.delete();
        push_pass(18'd32, 18'd200);
        base_src = 18'd32; base_dst = 18'd200; addr_ready = 1'b1;
        @(posedge clk); start = 1'b1;
        for (int cyc = 1; cyc <= 100 && !fin; cyc++) begin
            @(posedge clk); start = 1'b0;
            if (addr_valid) begin
                nx++;
                e = sb_q.pop_front();
                checks++;
                if ({addr_kind, addr_out} !== e) begin
                    errors++;
                    $display("FAIL midrst_pre%0d: kind=%0d addr=%h, required kind=%0d addr=%h",
                             nx, addr_kind, addr_out, e[AW+2:AW], e[AW-1:0]);
                end
            end
            if (nx == 7) fin = 1'b1;
        end
        @(posedge clk); rst = 1'b0;
        @(posedge clk);
        checks++;
        if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || addr_out !== '0) begin
            errors++;
            $display("FAIL midrst_state: valid=%b busy=%b done=%b addr=%h, required 0 0 0 0",
                     addr_valid, busy, done, addr_out);
        end
        rst = 1'b1;
        sb_q.delete();
        push_pass(18'd64, 18'd300);
        base_src = 18'd64; base_dst = 18'd300;
        nx = 0; fin = 1'b0;
        @(posedge clk); start = 1'b1;
        for (int cyc = 1; cyc <= 100 && !fin; cyc++) begin
            @(posedge clk); start = 1'b0;
            if (addr_valid) begin
                nx++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL midrst_extra: addr=%h, required no transfer", addr_out);
                end else begin
                    e = sb_q.pop_front();
                    if ({addr_kind, addr_out} !== e) begin
                        errors++;
                        $display("FAIL midrst_post%0d: kind=%0d addr=%h, required kind=%0d addr=%h",
                                 nx, addr_kind, addr_out, e[AW+2:AW], e[AW-1:0]);
                    end
                end
            end
            if (done) nd++;
            if (!busy && nd > 0) fin = 1'b1;
        end
        checks++;
        if (!fin || nx != 20 || nd != 1) begin
            errors++;
            $display("FAIL midrst_count: finished=%0d transfers=%0d dones=%0d, required 1 20 1", fin, nx, nd);
        end
    endtask

    task automatic test_start_busy();
        logic [AW+2:0] e;
        int nx = 0, nd = 0;
        bit fin = 1'b0;
        sb_q.delete();
        push_pass(18'd0, 18'd100);
        base_src = 18'd0; base_dst = 18'd100; addr_ready = 1'b1;
        @(posedge clk); start = 1'b1;
        for (int cyc = 1; cyc <= 100 && !fin; cyc++) begin
            @(posedge clk); start = 1'b0;
            if (cyc == 5 || cyc == 12) begin
                start = 1'b1;
                base_src = 18'd500;
            end
            if (addr_valid) begin
                nx++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL busy_extra: addr=%h, required no transfer", addr_out);
                end else begin
                    e = sb_q.pop_front();
                    if ({addr_kind, addr_out} !== e) begin
                        errors++;
                        $display("FAIL busy_xfer%0d: kind=%0d addr=%h, required kind=%0d addr=%h",
                                 nx, addr_kind, addr_out, e[AW+2:AW], e[AW-1:0]);
                    end
                end
            end
            if (done) begin
                nd++;
                start = 1'b1;
            end
            if (!busy && nd > 0) fin = 1'b1;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (!fin || nx != 20 || nd != 1 || busy !== 1'b0 || addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_count: finished=%0d transfers=%0d dones=%0d busy=%b valid=%b, required 1 20 1 0 0",
                     fin, nx, nd, busy, addr_valid);
        end
    endtask

    task automatic test_start_with_reset();
        @(posedge clk); rst = 1'b0; start = 1'b1;
        @(posedge clk);
        checks++;
        if (addr_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_start: valid=%b busy=%b, required 0 0", addr_valid, busy);
        end
        rst = 1'b1; start = 1'b0;
        @(posedge clk);
        checks++;
        if (addr_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_after: valid=%b busy=%b, required 0 0", addr_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_mid_reset();
        test_start_busy();
        test_start_with_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
